// File: rtl/fir_out_fifo_if.sv
// AXI-Stream beat bundle used on both sides of the FIR output elastic buffer.
interface fir_out_fifo_if #(
    parameter int DW = 32
);
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tready;

    // A beat transfers on a rising edge where tvalid && tready; the master holds tdata/tlast stable while tvalid && !tready.
    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/fir_out_fifo.sv
// Elastic buffer behind the FIR output: stores {tlast, tdata} beats, checks frame
// length against cfg_len on the input side and pulses frame_done on each tlast beat out.
module fir_out_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int pADDR_W     = 4
) (
    input  logic               axis_clk,
    input  logic               axis_rst_n,
    fir_out_fifo_if.slave      s_axis,
    fir_out_fifo_if.master     m_axis,
    input  logic [31:0]        cfg_len,
    input  logic               clr_err,
    output logic [pADDR_W:0]   level,
    output logic               frame_done,
    output logic               len_err
);
    localparam int                 pDEPTH  = 1 << pADDR_W;
    localparam logic [pADDR_W:0]   LV_FULL = (pADDR_W + 1)'(pDEPTH);
    localparam logic [pADDR_W:0]   LV_ONE  = (pADDR_W + 1)'(1);
    localparam logic [pADDR_W-1:0] PTR_ONE = pADDR_W'(1);

    logic [pDATA_WIDTH:0]   r_mem [pDEPTH];
    logic [pADDR_W-1:0]     r_wr_ptr;
    logic [pADDR_W-1:0]     r_rd_ptr;
    logic [pADDR_W:0]       r_level;
    logic [31:0]            r_in_cnt;
    logic                   r_len_err;
    logic                   r_frame_done;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_s_ready;
    logic                   w_m_valid;
    logic                   w_push;
    logic                   w_pop;
    logic [pDATA_WIDTH:0]   w_head;
    logic [31:0]            w_cnt_inc;
    logic [31:0]            w_cnt_nxt;
    logic                   w_len_evt;

    assign w_full    = (r_level == LV_FULL);
    assign w_empty   = (r_level == '0);
    // Both sides are held idle for the whole time reset is asserted, not only after its first edge.
    assign w_s_ready = axis_rst_n & ~w_full;
    assign w_m_valid = axis_rst_n & ~w_empty;
    assign w_push    = s_axis.tvalid & w_s_ready;
    assign w_pop     = w_m_valid & m_axis.tready;
    assign w_head    = r_mem[r_rd_ptr];

    assign s_axis.tready = w_s_ready;
    assign m_axis.tvalid = w_m_valid;
    assign m_axis.tdata  = w_head[pDATA_WIDTH-1:0];
    assign m_axis.tlast  = w_head[pDATA_WIDTH];
    assign level         = r_level;
    assign frame_done    = r_frame_done;
    assign len_err       = r_len_err;

    always_ff @(posedge axis_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LV_ONE;
                2'b01:   r_level <= r_level - LV_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    assign w_cnt_inc = r_in_cnt + 32'd1;

    // A frame ends either on tlast or when the programmed length is reached without it.
    always_comb begin
        w_len_evt = 1'b0;
        w_cnt_nxt = r_in_cnt;
        if (w_push) begin
            if (s_axis.tlast) begin
                w_len_evt = (cfg_len != 32'd0) && (w_cnt_inc != cfg_len);
                w_cnt_nxt = 32'd0;
            end else if ((cfg_len != 32'd0) && (w_cnt_inc == cfg_len)) begin
                w_len_evt = 1'b1;
                w_cnt_nxt = 32'd0;
            end else begin
                w_cnt_nxt = w_cnt_inc;
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            r_in_cnt     <= 32'd0;
            r_len_err    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_in_cnt     <= w_cnt_nxt;
            r_frame_done <= w_pop & w_head[pDATA_WIDTH];
            if (w_len_evt) begin
                r_len_err <= 1'b1;
            end else if (clr_err) begin
                r_len_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fir_out_fifo.sv
// Directed bench for fir_out_fifo: ordering, back-pressure, full streaming,
// frame-length checking and mid-frame reset.
module tb_fir_out_fifo;
    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   cfg_len = 32'd0;
    logic          clr_err = 1'b0;
    logic [AW:0]   level;
    logic          frame_done;
    logic          len_err;

    int            checks = 0;
    int            errors = 0;
    logic [DW:0]   exp_q[$];

    fir_out_fifo_if #(.DW(DW)) s_if ();
    fir_out_fifo_if #(.DW(DW)) m_if ();

    fir_out_fifo #(.pDATA_WIDTH(DW), .pADDR_W(AW)) dut (
        .axis_clk   (clk),
        .axis_rst_n (rst_n),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .cfg_len    (cfg_len),
        .clr_err    (clr_err),
        .level      (level),
        .frame_done (frame_done),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++; if (level !== '0) begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %b expected 0", m_if.tvalid); end
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b expected 0", s_if.tready); end
        checks++; if (len_err !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL rst_flags: got len_err=%b frame_done=%b expected 0/0", len_err, frame_done); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_if.tready !== 1'b1 || m_if.tvalid !== 1'b0) begin errors++; $display("FAIL post_rst_ready: got s_tready=%b m_tvalid=%b expected 1/0", s_if.tready, m_if.tvalid); end
        tick();
    endtask

    task automatic test_basic_frame();
        int vals[5] = '{10, -20, 30, -40, 50};
        logic [DW-1:0] d;
        cfg_len = 32'd5;
        m_if.tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_if.tvalid = (k < 5);
            s_if.tlast  = (k == 4);
            s_if.tdata  = '0;
            if (k < 5) s_if.tdata = vals[k];
            @(negedge clk);
            if (k >= 1 && k <= 5) begin
                d = vals[k-1];
                checks++;
                if (m_if.tvalid !== 1'b1 || m_if.tdata !== d || m_if.tlast !== (k == 5)) begin
                    errors++;
                    $display("FAIL basic_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", k, m_if.tvalid, m_if.tdata, m_if.tlast, d, (k == 5));
                end
            end else begin
                checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL basic_idle%0d: got m_tvalid=%b expected 0", k, m_if.tvalid); end
            end
            checks++; if (frame_done !== (k == 6)) begin errors++; $display("FAIL basic_frame_done%0d: got %b expected %b", k, frame_done, (k == 6)); end
            tick();
        end
        s_if.tvalid = 1'b0;
        @(negedge clk);
        checks++; if (len_err !== 1'b0 || level !== '0) begin errors++; $display("FAIL basic_end: got len_err=%b level=%0d expected 0/0", len_err, level); end
        tick();
    endtask

    task automatic test_back_pressure();
        int sent = 0;
        int popped = 0;
        logic [DW:0] exp_v;
        cfg_len = 32'd0;
        m_if.tready = 1'b0;
        for (int c = 0; c < 40 && sent < 16; c++) begin
            s_if.tvalid = 1'b1; s_if.tdata = 32'h100 + sent; s_if.tlast = (sent == 19);
            @(negedge clk);
            if (s_if.tready) begin exp_q.push_back({s_if.tlast, s_if.tdata}); sent++; end
            tick();
        end
        s_if.tdata = 32'h100 + sent;
        @(negedge clk);
        checks++; if (sent != 16) begin errors++; $display("FAIL bp_fill_timeout: got %0d accepted expected 16", sent); end
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", s_if.tready); end
        checks++; if (level !== (AW+1)'(16)) begin errors++; $display("FAIL bp_full_level: got %0d expected 16", level); end
        tick();
        m_if.tready = 1'b1;
        for (int c = 0; c < 60 && (sent < 20 || exp_q.size() != 0); c++) begin
            s_if.tvalid = (sent < 20); s_if.tdata = 32'h100 + sent; s_if.tlast = (sent == 19);
            @(negedge clk);
            if (m_if.tvalid && m_if.tready) begin
                popped++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra_beat: got %h expected none", m_if.tdata);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({m_if.tlast, m_if.tdata} !== exp_v) begin errors++; $display("FAIL bp_data: got %h expected %h", {m_if.tlast, m_if.tdata}, exp_v); end
                end
            end
            if (s_if.tvalid && s_if.tready) begin exp_q.push_back({s_if.tlast, s_if.tdata}); sent++; end
            tick();
        end
        s_if.tvalid = 1'b0;
        @(negedge clk);
        checks++; if (popped != 20) begin errors++; $display("FAIL bp_count: got %0d expected 20", popped); end
        checks++; if (level !== '0 || m_if.tvalid !== 1'b0) begin errors++; $display("FAIL bp_drained: got level=%0d m_tvalid=%b expected 0/0", level, m_if.tvalid); end
        tick();
    endtask

    task automatic test_full_stream();
        int sent = 0;
        logic [DW:0] exp_v;
        logic [AW:0] exp_lvl;
        exp_q.delete();
        cfg_len = 32'd0;
        m_if.tready = 1'b0;
        for (int c = 0; c < 40 && sent < 16; c++) begin
            s_if.tvalid = 1'b1; s_if.tdata = 32'h200 + sent; s_if.tlast = 1'b0;
            @(negedge clk);
            if (s_if.tready) begin exp_q.push_back({s_if.tlast, s_if.tdata}); sent++; end
            tick();
        end
        m_if.tready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            s_if.tvalid = 1'b1; s_if.tdata = 32'h200 + sent; s_if.tlast = (c == 9);
            @(negedge clk);
            exp_lvl = (c == 0) ? (AW+1)'(16) : (AW+1)'(15);
            checks++; if (s_if.tready !== (c != 0)) begin errors++; $display("FAIL full_ready%0d: got %b expected %b", c, s_if.tready, (c != 0)); end
            checks++; if (level !== exp_lvl) begin errors++; $display("FAIL full_level%0d: got %0d expected %0d", c, level, exp_lvl); end
            if (m_if.tvalid && m_if.tready && exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                checks++; if ({m_if.tlast, m_if.tdata} !== exp_v) begin errors++; $display("FAIL full_data%0d: got %h expected %h", c, {m_if.tlast, m_if.tdata}, exp_v); end
            end
            if (s_if.tvalid && s_if.tready) begin exp_q.push_back({s_if.tlast, s_if.tdata}); sent++; end
            tick();
        end
        s_if.tvalid = 1'b0;
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (m_if.tvalid && m_if.tready) begin
                exp_v = exp_q.pop_front();
                checks++; if ({m_if.tlast, m_if.tdata} !== exp_v) begin errors++; $display("FAIL full_drain: got %h expected %h", {m_if.tlast, m_if.tdata}, exp_v); end
            end
            tick();
        end
        @(negedge clk);
        checks++; if (exp_q.size() != 0 || level !== '0) begin errors++; $display("FAIL full_end: got left=%0d level=%0d expected 0/0", exp_q.size(), level); end
        tick();
    endtask

    task automatic test_len_short();
        logic [DW:0] exp_v;
        cfg_len = 32'd4;
        m_if.tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s_if.tvalid = (k < 3); s_if.tdata = 32'h300 + k; s_if.tlast = (k == 2);
            @(negedge clk);
            checks++; if (len_err !== (k >= 3)) begin errors++; $display("FAIL short_len_err%0d: got %b expected %b", k, len_err, (k >= 3)); end
            if (k >= 1 && k <= 3) begin
                exp_v = {(k == 3), 32'h300 + 32'(k - 1)};
                checks++; if (m_if.tvalid !== 1'b1 || {m_if.tlast, m_if.tdata} !== exp_v) begin errors++; $display("FAIL short_data%0d: got %h expected %h", k, {m_if.tlast, m_if.tdata}, exp_v); end
            end
            tick();
        end
        s_if.tvalid = 1'b0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        @(negedge clk);
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL short_clr: got %b expected 0", len_err); end
        tick();
        cfg_len = 32'd0;
        for (int k = 0; k < 4; k++) begin
            s_if.tvalid = (k < 2); s_if.tdata = 32'h380 + k; s_if.tlast = (k == 1);
            tick();
        end
        s_if.tvalid = 1'b0;
        @(negedge clk);
        checks++; if (len_err !== 1'b0 || level !== '0) begin errors++; $display("FAIL unchecked_frame: got len_err=%b level=%0d expected 0/0", len_err, level); end
        tick();
    endtask

    task automatic test_len_missing();
        logic vld_t[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic clr_t[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic err_t[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int sent = 0;
        logic [DW:0] exp_v;
        exp_q.delete();
        cfg_len = 32'd3;
        m_if.tready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            s_if.tvalid = vld_t[k]; s_if.tdata = 32'h400 + sent; s_if.tlast = 1'b0;
            clr_err = clr_t[k];
            @(negedge clk);
            checks++; if (len_err !== err_t[k]) begin errors++; $display("FAIL missing_len_err%0d: got %b expected %b", k, len_err, err_t[k]); end
            if (m_if.tvalid && m_if.tready && exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                checks++; if ({m_if.tlast, m_if.tdata} !== exp_v) begin errors++; $display("FAIL missing_data%0d: got %h expected %h", k, {m_if.tlast, m_if.tdata}, exp_v); end
            end
            if (s_if.tvalid && s_if.tready) begin exp_q.push_back({s_if.tlast, s_if.tdata}); sent++; end
            tick();
        end
        s_if.tvalid = 1'b0;
        clr_err = 1'b0;
        @(negedge clk);
        checks++; if (sent != 6 || exp_q.size() != 0) begin errors++; $display("FAIL missing_count: got sent=%0d left=%0d expected 6/0", sent, exp_q.size()); end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        int popped = 0;
        logic [DW:0] exp_v;
        exp_q.delete();
        cfg_len = 32'd10;
        m_if.tready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            s_if.tvalid = 1'b1; s_if.tdata = 32'h500 + k; s_if.tlast = 1'b0;
            tick();
        end
        s_if.tvalid = 1'b0;
        @(negedge clk);
        checks++; if (level !== (AW+1)'(7)) begin errors++; $display("FAIL mid_level: got %0d expected 7", level); end
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (level !== '0 || m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0) begin errors++; $display("FAIL mid_reset: got level=%0d m_tvalid=%b s_tready=%b expected 0/0/0", level, m_if.tvalid, s_if.tready); end
        tick();
        rst_n = 1'b1;
        cfg_len = 32'd3;
        m_if.tready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            s_if.tvalid = (k < 3); s_if.tdata = 32'h600 + k; s_if.tlast = (k == 2);
            @(negedge clk);
            if (m_if.tvalid && m_if.tready) begin
                popped++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL mid_stale_beat: got %h expected none", {m_if.tlast, m_if.tdata});
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({m_if.tlast, m_if.tdata} !== exp_v) begin errors++; $display("FAIL mid_data%0d: got %h expected %h", k, {m_if.tlast, m_if.tdata}, exp_v); end
                end
            end
            if (s_if.tvalid && s_if.tready) exp_q.push_back({s_if.tlast, s_if.tdata});
            tick();
        end
        s_if.tvalid = 1'b0;
        @(negedge clk);
        checks++; if (popped != 3) begin errors++; $display("FAIL mid_count: got %0d expected 3", popped); end
        checks++; if (len_err !== 1'b0 || level !== '0) begin errors++; $display("FAIL mid_fresh_frame: got len_err=%b level=%0d expected 0/0", len_err, level); end
        tick();
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        test_reset();
        test_basic_frame();
        test_back_pressure();
        test_full_stream();
        test_len_short();
        test_len_missing();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
